// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider with boundary-aligned divisor changes.
// Optional CLKDIV_TICK_EN adds a registered clk-domain pulse marking each clk_out rise.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_err,
    output logic             clk_out
`ifdef CLKDIV_TICK_EN
    ,
    output logic             tick
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] pend;
    logic             pend_vld;
    logic             odd_cur;
    logic             v1;
    logic             v1n;

    logic             load_ok;
    logic [CNT_W-1:0] div_sel;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] half_cur;
    logic             wrap;

    always_comb begin
        load_ok  = div_load && (div_val >= TWO);
        div_sel  = div_cur;
        if (load_ok) begin
            div_sel = div_val;
        end else if (pend_vld) begin
            div_sel = pend;
        end
        cnt_inc  = cnt + ONE;
        half_cur = div_cur >> 1;
        // IDLE behaves like a permanent period boundary
        wrap     = (state == IDLE) || (cnt == div_cur - ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_cur  <= DIV_RST;
            pend     <= '0;
            pend_vld <= 1'b0;
            odd_cur  <= DIV_RST[0];
            v1       <= 1'b0;
            div_err  <= 1'b0;
`ifdef CLKDIV_TICK_EN
            tick     <= 1'b0;
`endif
        end else begin
            div_err <= div_load && (div_val < TWO);
            if (wrap) begin
                cnt      <= '0;
                div_cur  <= div_sel;
                odd_cur  <= div_sel[0];
                pend_vld <= 1'b0;
                state    <= en ? RUN : IDLE;
                // div_sel >= 2, so the first cycle of a period is always high
                v1       <= en;
`ifdef CLKDIV_TICK_EN
                tick     <= en;
`endif
            end else begin
                cnt <= cnt_inc;
                v1  <= cnt_inc < half_cur;
`ifdef CLKDIV_TICK_EN
                tick <= 1'b0;
`endif
                if (load_ok) begin
                    pend     <= div_val;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

    // Half-cycle extension for odd divisors
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1n <= 1'b0;
        end else begin
            v1n <= v1;
        end
    end

    assign clk_out = v1 | (odd_cur & v1n);

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: half-cycle waveform model plus directed period measurements.
// Model: clk_out is high for the first N half-cycles of each 2N half-cycle period.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_err;
    logic       clk_out;
`ifdef CLKDIV_TICK_EN
    logic       tick;
`endif

    int tests = 0;
    int fails = 0;
    int rises = 0;
    int ticks = 0;

    always #5 clk = ~clk;

    clk_div_prog dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_val (div_val),
        .div_load(div_load),
        .div_err (div_err),
        .clk_out (clk_out)
`ifdef CLKDIV_TICK_EN
        ,
        .tick    (tick)
`endif
    );

    // Behavioural model
    logic m_run = 1'b0;
    int   m_pos = 0;
    int   m_n   = 5;
    int   m_pend = 0;
    logic m_pv  = 1'b0;
    logic m_err = 1'b0;
    logic m_ok;

    assign m_ok = div_load && (div_val >= 8'd2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_pos <= 0;
            m_n   <= 5;
            m_pv  <= 1'b0;
            m_err <= 1'b0;
        end else begin
            m_err <= div_load && (div_val < 8'd2);
            if (!m_run || m_pos == m_n - 1) begin
                if (m_ok) m_n <= int'(div_val);
                else if (m_pv) m_n <= m_pend;
                m_pv  <= 1'b0;
                m_pos <= 0;
                m_run <= en;
            end else begin
                m_pos <= m_pos + 1;
                if (m_ok) begin
                    m_pend <= int'(div_val);
                    m_pv   <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int h);
        logic exp_out;
        exp_out = m_run && (2 * m_pos + h < m_n);
        chk("clk_out", int'(clk_out), int'(exp_out));
        chk("div_err", int'(div_err), int'(m_err));
`ifdef CLKDIV_TICK_EN
        chk("tick", int'(tick), int'(m_run && m_pos == 0));
        if (h == 0 && tick === 1'b1) ticks++;
`endif
    endtask

    always begin
        @(posedge clk);
        #1 cmp(0);
    end

    always begin
        @(negedge clk);
        #1 cmp(1);
    end

    always @(posedge clk_out) rises++;

    task automatic half(output logic s);
        @(posedge clk or negedge clk);
        #1 s = clk_out;
    endtask

    task automatic wait_rise();
        logic s;
        int   g;
        g = 0;
        do begin half(s); g++; end while (s === 1'b1 && g < 2000);
        while (s !== 1'b1 && g < 2000) begin half(s); g++; end
        if (g >= 2000) chk("rise_timeout", 0, 1);
    endtask

    task automatic measure(input string nm, input int hi_exp, input int per_exp);
        logic s;
        int   hi;
        int   per;
        int   g;
        hi  = 0;
        per = 0;
        g   = 0;
        wait_rise();
        s = clk_out;
        while (s === 1'b1 && g < 2000) begin hi++; per++; half(s); g++; end
        while (s !== 1'b1 && g < 2000) begin per++; half(s); g++; end
        chk({nm, "_high"}, hi, hi_exp);
        chk({nm, "_period"}, per, per_exp);
    endtask

    task automatic pulse_load(input logic [7:0] v);
        @(negedge clk);
        div_load = 1'b1;
        div_val  = v;
        @(posedge clk);
        #1;
        if (v < 8'd2) chk("err_pulse", int'(div_err), 1);
        @(negedge clk);
        div_load = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = 8'd0;
        #22;
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_div_err", int'(div_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_low", int'(clk_out), 0);

        // T1: default N=5
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 chk("first_rise", int'(clk_out), 1);
        measure("n5a", 5, 10);
        measure("n5b", 5, 10);

        // T2: mid-period load of 4
        pulse_load(8'd4);
        measure("n4", 4, 8);

        // T3
        pulse_load(8'd2);
        measure("n2", 2, 4);
        pulse_load(8'd3);
        measure("n3", 3, 6);
        pulse_load(8'd255);
        measure("n255", 255, 510);

        // T4: rejected loads
        pulse_load(8'd1);
        pulse_load(8'd0);
        measure("n255_keep", 255, 510);

        // T5: stop mid-period
        pulse_load(8'd6);
        measure("n6", 6, 12);
        wait_rise();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("stopped_low", int'(clk_out), 0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 chk("restart_rise", int'(clk_out), 1);
        measure("n6_restart", 6, 12);

        // T6: reset while high
        pulse_load(8'd7);
        measure("n7", 7, 14);
        wait_rise();
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst_high", int'(clk_out), 1);
        rst_n = 1'b0;
        #1 chk("async_rst_low", int'(clk_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        measure("n5_after_rst", 5, 10);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 19) != 0);
            div_load = ($urandom_range(0, 7) == 0);
            div_val  = 8'($urandom_range(0, 9));
        end
        @(negedge clk);
        div_load = 1'b0;
        en       = 1'b0;
        repeat (20) @(posedge clk);
        #2;

`ifdef CLKDIV_TICK_EN
        chk("tick_count", ticks, rises);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
